inv_key_stepper: RTL and testbench

Sequential AES-128 inverse key scheduler. Takes a key, then produces round keys from round 10 down to round 0, one round per `step` request. Each backward step runs the schedule recurrence in reverse, so the decryption datapath gets its round keys on the fly without storing all 11. It sits between the key register and the inverse-cipher round logic, and uses a synchronous one-cycle S-box word unit.

---
 rtl/aes_key_pkg.sv | 47 ++++
 rtl/rot_sub_word_sync.sv | 61 ++++++
 rtl/inv_key_stepper.sv | 118 +++++++++++
 tb/tb_inv_key_stepper.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/aes_key_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_pkg
// Brief    : AES-128 key-schedule constants, types, FSM states and rcon.
//            Optional macro: INV_KEY_FWD_PRECOMPUTE_EN (adds forward states).
// Revision : 1.0  initial release
// ============================================================================
package aes_key_pkg;

    localparam int NK = 4;
    localparam int NR = 10;

    typedef logic [NK*32-1:0] key_t;
    typedef logic [31:0]      word_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
`ifdef INV_KEY_FWD_PRECOMPUTE_EN
        FWD_SUB = 3'd1,
        FWD_MIX = 3'd2,
`endif
        READY   = 3'd3,
        INV_SUB = 3'd4,
        INV_MIX = 3'd5
    } state_t;

    // Round constant for round index r (1..10), placed in the MSB byte.
    function automatic word_t rcon(input logic [3:0] r);
        logic [7:0] b;
        case (r)
            4'd1:    b = 8'h01;
            4'd2:    b = 8'h02;
            4'd3:    b = 8'h04;
            4'd4:    b = 8'h08;
            4'd5:    b = 8'h10;
            4'd6:    b = 8'h20;
            4'd7:    b = 8'h40;
            4'd8:    b = 8'h80;
            4'd9:    b = 8'h1b;
            4'd10:   b = 8'h36;
            default: b = 8'h00;
        endcase
        return {b, 24'h000000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rot_sub_word_sync.sv
`default_nettype none
// ============================================================================
// Module   : rot_sub_word_sync
// Brief    : Registered SubWord(RotWord(word_in)); one cycle of latency.
// Revision : 1.0  initial release
// ============================================================================
module rot_sub_word_sync
    import aes_key_pkg::*;
(
    input  logic  clk,
    input  logic  nreset,
    input  word_t word_in,
    output word_t word_out
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the AES affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    word_t      rot;
    logic [7:0] sub_b [4];

    assign rot = {word_in[23:0], word_in[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        assign sub_b[i] = sbox(rot[8*i +: 8]);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) word_out <= '0;
        else         word_out <= {sub_b[3], sub_b[2], sub_b[1], sub_b[0]};
    end

endmodule
`default_nettype wire

// File: rtl/inv_key_stepper.sv
`default_nettype none
// ============================================================================
// Module   : inv_key_stepper
// Brief    : Sequential AES-128 inverse key scheduler, round 10 down to 0.
//            Optional macro: INV_KEY_FWD_PRECOMPUTE_EN (key_in is round-0 key).
// Revision : 1.0  initial release
// ============================================================================
module inv_key_stepper
    import aes_key_pkg::*;
(
    input  logic         clk,
    input  logic         nreset,
    input  logic         load,
    input  logic [127:0] key_in,
    input  logic         step,
    output logic [127:0] round_key,
    output logic [3:0]   round,
    output logic         key_valid,
    output logic         busy
);

    state_t state;
    word_t  sbox_in;
    word_t  sbox_out;

    word_t k0, k1, k2, k3;
    assign k0 = round_key[127:96];
    assign k1 = round_key[95:64];
    assign k2 = round_key[63:32];
    assign k3 = round_key[31:0];

    // Backward recurrence: current words act as w4..w7 of the next-higher round.
    word_t inv_w0, inv_w1, inv_w2, inv_w3;
    assign inv_w3 = k3 ^ k2;
    assign inv_w2 = k2 ^ k1;
    assign inv_w1 = k1 ^ k0;
    assign inv_w0 = k0 ^ sbox_out ^ rcon(round);

`ifdef INV_KEY_FWD_PRECOMPUTE_EN
    word_t fwd_w4, fwd_w5, fwd_w6, fwd_w7;
    assign fwd_w4 = k0 ^ sbox_out ^ rcon(4'(round + 4'd1));
    assign fwd_w5 = k1 ^ fwd_w4;
    assign fwd_w6 = k2 ^ fwd_w5;
    assign fwd_w7 = k3 ^ fwd_w6;
`endif

    always_comb begin
        sbox_in = inv_w3;
`ifdef INV_KEY_FWD_PRECOMPUTE_EN
        if (state == FWD_SUB) sbox_in = k3;
`endif
    end

    rot_sub_word_sync u_rot_sub (
        .clk      (clk),
        .nreset   (nreset),
        .word_in  (sbox_in),
        .word_out (sbox_out)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            round_key <= '0;
            round     <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (load) begin
            round_key <= key_in;
`ifdef INV_KEY_FWD_PRECOMPUTE_EN
            state     <= FWD_SUB;
            round     <= 4'd0;
            key_valid <= 1'b0;
            busy      <= 1'b1;
`else
            state     <= READY;
            round     <= 4'(NR);
            key_valid <= 1'b1;
            busy      <= 1'b0;
`endif
        end else begin
            case (state)
                READY: begin
                    if (step && round != 4'd0) begin
                        state     <= INV_SUB;
                        key_valid <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                INV_SUB: state <= INV_MIX;
                INV_MIX: begin
                    round_key <= {inv_w0, inv_w1, inv_w2, inv_w3};
                    round     <= round - 4'd1;
                    state     <= READY;
                    key_valid <= 1'b1;
                    busy      <= 1'b0;
                end
`ifdef INV_KEY_FWD_PRECOMPUTE_EN
                FWD_SUB: state <= FWD_MIX;
                FWD_MIX: begin
                    round_key <= {fwd_w4, fwd_w5, fwd_w6, fwd_w7};
                    round     <= round + 4'd1;
                    if (round == 4'(NR - 1)) begin
                        state     <= READY;
                        key_valid <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        state     <= FWD_SUB;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inv_key_stepper.sv
`default_nettype none
// ============================================================================
// Module   : tb_inv_key_stepper
// Brief    : Directed self-checking bench using FIPS-197 A.1 round keys.
// Revision : 1.0  initial release
// ============================================================================
module tb_inv_key_stepper;

    logic         clk = 1'b0;
    logic         nreset;
    logic         load;
    logic [127:0] key_in;
    logic         step;
    logic [127:0] round_key;
    logic [3:0]   round;
    logic         key_valid;
    logic         busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
    } vec_t;
    vec_t         tab [11];
    logic [127:0] load_key;

    always #5 clk = ~clk;

    inv_key_stepper dut (
        .clk       (clk),
        .nreset    (nreset),
        .load      (load),
        .key_in    (key_in),
        .step      (step),
        .round_key (round_key),
        .round     (round),
        .key_valid (key_valid),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string name, input logic [3:0] r, input logic [127:0] k,
                             input logic v, input logic b);
        chk({name, ".round"}, 128'(round), 128'(r));
        chk({name, ".key"}, round_key, k);
        chk({name, ".valid"}, 128'(key_valid), 128'(v));
        chk({name, ".busy"}, 128'(busy), 128'(b));
    endtask

    // Load and wait until round 10 is presented.
    task automatic do_load(input string name);
        key_in = load_key;
        load   = 1'b1;
        tick();
        load   = 1'b0;
`ifdef INV_KEY_FWD_PRECOMPUTE_EN
        chk_state({name, ".fwd0"}, 4'd0, tab[0].key, 1'b0, 1'b1);
        repeat (19) tick();
        chk({name, ".fwd19.busy"}, 128'(busy), 128'(1'b1));
        chk({name, ".fwd19.valid"}, 128'(key_valid), 128'(1'b0));
        tick();
`endif
        chk_state({name, ".r10"}, 4'd10, tab[10].key, 1'b1, 1'b0);
    endtask

    initial begin
        tab[0]  = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        tab[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        tab[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        tab[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        tab[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
        tab[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        tab[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        tab[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        tab[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
        tab[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
        tab[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
`ifdef INV_KEY_FWD_PRECOMPUTE_EN
        load_key = tab[0].key;
`else
        load_key = tab[10].key;
`endif

        nreset = 1'b1;
        load   = 1'b0;
        step   = 1'b0;
        key_in = '0;
        #2 nreset = 1'b0;
        #1;
        chk_state("reset", 4'd0, 128'h0, 1'b0, 1'b0);
        tick();
        nreset = 1'b1;
        step   = 1'b1;
        repeat (3) tick();
        step   = 1'b0;
        chk_state("idle_step", 4'd0, 128'h0, 1'b0, 1'b0);

        // Single steps through the table, checking SUB/MIX phases each round.
        do_load("load1");
        for (int i = 9; i >= 0; i--) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            chk_state($sformatf("sub%0d", i), tab[i+1].rnd, tab[i+1].key, 1'b0, 1'b1);
            tick();
            chk_state($sformatf("mix%0d", i), tab[i+1].rnd, tab[i+1].key, 1'b0, 1'b1);
            tick();
            chk_state($sformatf("step%0d", i), tab[i].rnd, tab[i].key, 1'b1, 1'b0);
        end

        // Step at round 0 is ignored.
        step = 1'b1;
        tick();
        step = 1'b0;
        chk_state("r0_step", 4'd0, tab[0].key, 1'b1, 1'b0);
        tick();
        chk_state("r0_step2", 4'd0, tab[0].key, 1'b1, 1'b0);

        // Step held high: 3-cycle cadence, 30 cycles for the full walk.
        do_load("load2");
        step = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            tick();
            if (c % 3 == 0) begin
                if (c <= 30)
                    chk_state($sformatf("held%0d", c), tab[10 - c/3].rnd, tab[10 - c/3].key,
                              1'b1, 1'b0);
                else
                    chk_state("held_r0", 4'd0, tab[0].key, 1'b1, 1'b0);
            end else if (c < 30) begin
                chk($sformatf("held%0d.busy", c), 128'(busy), 128'(1'b1));
            end
        end
        step = 1'b0;

        // Load during INV_MIX discards the in-flight step.
        do_load("load3");
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        chk("mid.busy", 128'(busy), 128'(1'b1));
        do_load("load_mid");
        repeat (3) tick();
        chk_state("load_mid.hold", 4'd10, tab[10].key, 1'b1, 1'b0);

        // Load together with step at round 9.
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (2) tick();
        chk_state("pre_both", 4'd9, tab[9].key, 1'b1, 1'b0);
        step = 1'b1;
        do_load("load_both");
        step = 1'b0;
        tick();
        chk_state("both.after", 4'd10, tab[10].key, 1'b1, 1'b0);

        // Asynchronous reset in INV_SUB.
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("pre_rst.busy", 128'(busy), 128'(1'b1));
        #2 nreset = 1'b0;
        #1;
        chk_state("async_rst", 4'd0, 128'h0, 1'b0, 1'b0);
        tick();
        nreset = 1'b1;
        step   = 1'b1;
        repeat (4) tick();
        step   = 1'b0;
        chk_state("post_rst", 4'd0, 128'h0, 1'b0, 1'b0);
        do_load("load_rst");
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (2) tick();
        chk_state("post_rst.step", 4'd9, tab[9].key, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
